// File: rtl/fx2_pipe.sv
// Halfword/word shift and rotate unit followed by a fixed-latency, flushable
// writeback pipeline. Vectors use MSB-first [0:N-1] numbering; element 0 is the most significant.
module fx2_pipe #(
  parameter int unsigned LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [0:2]             op,
  input  logic [0:127]           ra,
  input  logic [0:127]           rb,
  input  logic [0:6]             imme7,
  input  logic [0:6]             rt_addr,
  input  logic                   flush,
  output logic [0:LATENCY-1]     pend_valid,
  output logic [0:7*LATENCY-1]   pend_addr,
  output logic                   wb_valid,
  output logic [0:6]             wb_addr,
  output logic [0:127]           wb_data
);

  typedef enum logic [2:0] {
    OP_SHLH  = 3'b000,
    OP_SHLHI = 3'b001,
    OP_ROTH  = 3'b010,
    OP_ROTHI = 3'b011,
    OP_SHL   = 3'b100,
    OP_SHLI  = 3'b101,
    OP_ROT   = 3'b110,
    OP_ROTI  = 3'b111
  } op_e;

  op_e          op_s;
  logic         is_word;
  logic         is_rot;
  logic         is_imm;
  logic [0:127] alu_res;
  logic [15:0]  h_el;
  logic [15:0]  h_cnt;
  logic [15:0]  h_res;
  logic [31:0]  w_el;
  logic [31:0]  w_cnt;
  logic [31:0]  w_res;

  logic         valid_q [LATENCY];
  logic         valid_d [LATENCY];
  logic [6:0]   addr_q  [LATENCY];
  logic [6:0]   addr_d  [LATENCY];
  logic [127:0] data_q  [LATENCY];
  logic [127:0] data_d  [LATENCY];

  always_comb begin
    op_s    = op_e'(op);
    is_word = op_s inside {OP_SHL, OP_SHLI, OP_ROT, OP_ROTI};
    is_rot  = op_s inside {OP_ROTH, OP_ROTHI, OP_ROT, OP_ROTI};
    is_imm  = op_s inside {OP_SHLHI, OP_ROTHI, OP_SHLI, OP_ROTI};
  end

  // Counts are masked at full element width so shifts of 16/32 or more fall out as zero.
  always_comb begin
    alu_res = '0;
    h_el    = '0;
    h_cnt   = '0;
    h_res   = '0;
    w_el    = '0;
    w_cnt   = '0;
    w_res   = '0;
    for (int unsigned h = 0; h < 8; h++) begin
      h_el  = ra[h*16 +: 16];
      h_cnt = (is_imm ? {{9{imme7[0]}}, imme7} : rb[h*16 +: 16])
              & (is_rot ? 16'h000F : 16'h001F);
      if (is_rot)
        h_res = (h_el << h_cnt) | (h_el >> (16'd16 - h_cnt));
      else
        h_res = (h_cnt >= 16'd16) ? '0 : (h_el << h_cnt);
      if (!is_word)
        alu_res[h*16 +: 16] = h_res;
    end
    for (int unsigned w = 0; w < 4; w++) begin
      w_el  = ra[w*32 +: 32];
      w_cnt = (is_imm ? {{25{imme7[0]}}, imme7} : rb[w*32 +: 32])
              & (is_rot ? 32'h0000_001F : 32'h0000_003F);
      if (is_rot)
        w_res = (w_el << w_cnt) | (w_el >> (32'd32 - w_cnt));
      else
        w_res = (w_cnt >= 32'd32) ? '0 : (w_el << w_cnt);
      if (is_word)
        alu_res[w*32 +: 32] = w_res;
    end
  end

  always_comb begin
    valid_d[0] = issue_valid & ~flush;
    addr_d[0]  = issue_valid ? rt_addr : addr_q[0];
    data_d[0]  = issue_valid ? alu_res : data_q[0];
    for (int unsigned k = 1; k < LATENCY; k++) begin
      valid_d[k] = valid_q[k-1] & ~flush;
      addr_d[k]  = addr_q[k-1];
      data_d[k]  = data_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        valid_q[k] <= 1'b0;
        addr_q[k]  <= '0;
        data_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        valid_q[k] <= valid_d[k];
        addr_q[k]  <= addr_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end

  always_comb begin
    pend_valid = '0;
    pend_addr  = '0;
    for (int unsigned k = 0; k < LATENCY; k++) begin
      pend_valid[k]       = valid_q[k];
      pend_addr[k*7 +: 7] = addr_q[k];
    end
  end

  assign wb_valid = valid_q[LATENCY-1];
  assign wb_addr  = addr_q[LATENCY-1];
  assign wb_data  = data_q[LATENCY-1];

endmodule

// File: tb/tb_fx2_pipe.sv
// Directed-vector bench for fx2_pipe: shift/rotate results, pipeline latency,
// flush and mid-operation reset behaviour.
module tb_fx2_pipe;
  localparam int unsigned LAT = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_valid;
  logic [0:2]       op;
  logic [0:127]     ra;
  logic [0:127]     rb;
  logic [0:6]       imme7;
  logic [0:6]       rt_addr;
  logic             flush;
  logic [0:LAT-1]   pend_valid;
  logic [0:7*LAT-1] pend_addr;
  logic             wb_valid;
  logic [0:6]       wb_addr;
  logic [0:127]     wb_data;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  fx2_pipe #(.LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_valid),
    .op         (op),
    .ra         (ra),
    .rb         (rb),
    .imme7      (imme7),
    .rt_addr    (rt_addr),
    .flush      (flush),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction with nothing else in flight and follow it to writeback.
  task automatic vec(input string tag, input logic [2:0] o, input logic [127:0] a,
                     input logic [127:0] b, input logic [6:0] im, input logic [6:0] ad,
                     input logic [127:0] exp);
    op = o; ra = a; rb = b; imme7 = im; rt_addr = ad; issue_valid = 1'b1;
    tick;
    issue_valid = 1'b0;
    check({tag, ".pv1"}, pend_valid[0], 1);
    check({tag, ".pa1"}, pend_addr[0:6], ad);
    repeat (LAT-2) tick;
    check({tag, ".early"}, wb_valid, 0);
    tick;
    check({tag, ".wbv"}, wb_valid, 1);
    check({tag, ".wba"}, wb_addr, ad);
    check({tag, ".wbd"}, wb_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; flush = 1'b0;
    op = '0; ra = '0; rb = '0; imme7 = '0; rt_addr = '0;
    repeat (2) tick;
    check("rst.wbv", wb_valid, 0);
    check("rst.wba", wb_addr, 0);
    check("rst.wbd", wb_data, 0);
    check("rst.pv", pend_valid, 0);
    check("rst.pa", pend_addr, 0);
    rst_n = 1'b1;
    tick;

    vec("shlhi3", 3'b001, {8{16'h0001}}, '0, 7'h03, 7'd5, {8{16'h0008}});
    vec("shlhi_neg", 3'b001, {128{1'b1}}, '0, 7'h7F, 7'd7, '0);
    vec("roth", 3'b010, {8{16'h8001}}, {8{16'h0011}}, 7'h00, 7'd11, {8{16'h0003}});
    vec("rot", 3'b110, {4{32'h8000_0000}}, {4{32'h0000_0021}}, 7'h00, 7'd12, {4{32'h0000_0001}});
    vec("shl32", 3'b100, {128{1'b1}}, {4{32'd32}}, 7'h00, 7'd13, '0);
    vec("shl63", 3'b100, {128{1'b1}}, {4{32'h3F}}, 7'h00, 7'd14, '0);
    vec("shl4", 3'b100, {128{1'b1}}, {4{32'd4}}, 7'h00, 7'd15, {4{32'hFFFF_FFF0}});
    vec("shl_mix", 3'b100, {128{1'b1}}, {32'd4, 32'd32, 32'd63, 32'd0}, 7'h00, 7'd16,
        {32'hFFFF_FFF0, 32'h0, 32'h0, 32'hFFFF_FFFF});
    vec("shlh_mix", 3'b000, {8{16'h1234}},
        {16'd0, 16'd1, 16'd4, 16'd8, 16'd3, 16'd16, 16'd17, 16'd31}, 7'h00, 7'd17,
        {16'h1234, 16'h2468, 16'h2340, 16'h3400, 16'h91A0, 16'h0, 16'h0, 16'h0});
    vec("rothi_neg", 3'b011, {8{16'h1234}}, '0, 7'h7C, 7'd18, {8{16'h4123}});
    vec("roti8", 3'b111, {4{32'h1234_5678}}, '0, 7'h08, 7'd19, {4{32'h3456_7812}});
    vec("shli_m64", 3'b101, {4{32'h1234_5678}}, '0, 7'h40, 7'd20, {4{32'h1234_5678}});
    vec("shli_m32", 3'b101, {4{32'h1234_5678}}, '0, 7'h60, 7'd21, '0);

    // Flush: four back-to-back issues, flush alongside the fourth.
    for (int i = 1; i <= 4; i++) begin
      op = 3'b001; ra = {8{16'h0001}}; rb = '0; imme7 = 7'h01;
      rt_addr = 7'(i); issue_valid = 1'b1; flush = (i == 4);
      tick;
      check("flush.pre", wb_valid, 0);
    end
    issue_valid = 1'b0; flush = 1'b0;
    check("flush.pv", pend_valid, 0);
    rt_addr = 7'd6; issue_valid = 1'b1;
    tick;
    issue_valid = 1'b0;
    for (int c = 0; c < int'(LAT) - 1; c++) begin
      check("flush.quiet", wb_valid, 0);
      tick;
    end
    check("flush.wbv", wb_valid, 1);
    check("flush.wba", wb_addr, 6);
    check("flush.wbd", wb_data, {8{16'h0002}});
    tick;

    // Reset two cycles after issue; an issue during reset is also dropped.
    op = 3'b101; ra = {4{32'h0000_00FF}}; imme7 = 7'h04; rt_addr = 7'd9; issue_valid = 1'b1;
    tick;
    issue_valid = 1'b0;
    tick;
    rst_n = 1'b0; issue_valid = 1'b1; rt_addr = 7'd10;
    tick;
    rst_n = 1'b1; issue_valid = 1'b0;
    check("mrst.wbv", wb_valid, 0);
    check("mrst.wba", wb_addr, 0);
    check("mrst.wbd", wb_data, 0);
    check("mrst.pv", pend_valid, 0);
    check("mrst.pa", pend_addr, 0);
    for (int c = 0; c < 6; c++) begin
      tick;
      check("mrst.quiet", wb_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/fx2_pipe.md
FX2_PIPE -- requirements
Module: fx2_pipe

Interface
REQ-001 SHALL provide parameter: LATENCY, 4, number of pipeline stages from issue to writeback (legal range 2..6).
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL provide the following ports (bit 0 = MSB; all vectors [0:N-1]):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- issue_valid  in  1  an instruction is issued this cycle.
- op  in  3  operation select: 000 shlh, 001 shlhi, 010 roth, 011 rothi, 100 shl, 101 shli, 110 rot, 111 roti.
- ra  in  128  source operand.
- rb  in  128  per-element shift/rotate count (register forms only).
- imme7  in  7  signed immediate count (immediate forms only).
- rt_addr  in  7  destination register number.
- flush  in  1  kill all in-flight instructions.
- pend_valid  out  LATENCY  per-stage valid; bit k = stage k+1.
- pend_addr  out  7*LATENCY  per-stage rt_addr; field k = stage k+1.
- wb_valid  out  1  writeback strobe (final stage valid).
- wb_addr  out  7  writeback register number.
- wb_data  out  128  writeback result.

Function
REQ-004 SHALL compute the result combinationally in the issue cycle and capture it into stage 1 at the next rising edge.
REQ-005 Halfword ops (shlh, shlhi, roth, rothi) SHALL operate on 8 independent 16-bit elements; word ops (shl, shli, rot, roti) SHALL operate on 4 independent 32-bit elements.
REQ-006 Register-form count SHALL be the element of rb at the same position as the ra element.
REQ-007 Immediate-form count SHALL be imme7 sign-extended to the element width, then masked.
REQ-008 Counts SHALL be masked as follows: shlh/shlhi with 0x1F, roth/rothi with 0x0F, shl/shli with 0x3F, rot/roti with 0x1F.
REQ-009 For shifts, each destination bit b SHALL be source bit b+count when b+count < element width, else 0; a masked count of 16 or more (halfword) or 32 or more (word) SHALL yield 0.
REQ-010 For rotates, destination bit b SHALL be source bit (b+count) mod element width.
REQ-011 Stage k SHALL advance to stage k+1 every cycle, with no stall; an instruction issued at edge N SHALL present wb_valid=1 with its wb_addr/wb_data during the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after issue.
REQ-012 Stage 1 valid SHALL be loaded with issue_valid & ~flush; when issue_valid=0, stage 1 data/addr SHALL hold their previous values.
REQ-013 flush=1 SHALL clear every stage valid at the same edge; data and addr registers SHALL NOT be cleared by flush.
REQ-014 When flush and issue_valid are asserted in the same cycle, the issued instruction SHALL be discarded.
REQ-015 Consumers qualify data by valid only; wb_data/wb_addr SHALL be don't-care when wb_valid=0 (except after reset, REQ-017).
REQ-016 pend_valid/pend_addr SHALL reflect register state only, with no combinational path from inputs, for use in hazard detection by issue logic.

Reset
REQ-017 With rst_n=0 at a rising edge, all stage valid, addr and data registers SHALL become 0, so wb_valid=0, wb_addr=0, wb_data=0 and pend_valid=0.
REQ-018 Reset SHALL take priority over issue_valid and flush; an instruction issued during reset SHALL be discarded, and in-flight instructions SHALL be lost.

Verification
REQ-019 Bench SHALL cover shlhi: ra=all halfwords 0x0001, imme7=0x03, rt_addr=5 -> 4 cycles later wb_valid=1, wb_addr=5, wb_data=all halfwords 0x0008.
REQ-020 Bench SHALL cover the shlhi negative immediate: imme7=0x7F (masked count 0x1F), ra=all ones -> wb_data=0.
REQ-021 Bench SHALL cover roth: ra halfword 0x8001, rb halfword 0x0011 (masked count 1) -> 0x0003; and rot: ra word 0x80000000, count 0x21 -> 0x00000001.
REQ-022 Bench SHALL cover shl: ra word 0xFFFFFFFF, rb word count 32 -> 0; count 0x3F -> 0; count 4 -> 0xFFFFFFF0.
REQ-023 Bench SHALL cover flush: issue addr 1,2,3,4 on consecutive cycles, flush in the cycle addr 4 is issued -> no writeback for any of 1-4; an instruction issued the cycle after flush writes back normally.
REQ-024 Bench SHALL cover reset mid-operation: issue addr 9, assert rst_n=0 two cycles later for one cycle -> wb_valid never asserts for addr 9, and all outputs read 0 after the reset edge.
